// File: rtl/mixer_ctrl_pkg.sv
// Shared types, register offsets and helpers for the mixer layer offset writer.
package mixer_ctrl_pkg;

   localparam int unsigned COORD_W = 12;
   localparam int unsigned ADDR_W  = 32;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned BURST_W = 11;
   localparam int unsigned BE_W    = 4;
   localparam int unsigned DROP_W  = 16;

   localparam int unsigned REG_X    = 0;
   localparam int unsigned REG_Y    = 1;
   localparam int unsigned REG_CTRL = 2;

   localparam logic [BE_W-1:0] BYTEEN_ALL = 4'hF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARMED,
      ST_WR_X,
      ST_WR_Y,
      ST_WR_CTRL
   } state_t;

   // Saturate a requested offset to the largest legal value.
   function automatic logic [COORD_W-1:0] clamp_coord(input logic [COORD_W-1:0] v,
                                                      input logic [COORD_W-1:0] max_v);
      return (v > max_v) ? max_v : v;
   endfunction

endpackage

// File: rtl/mixer_layer_offset_writer_if.sv
// Update port plus Avalon-MM write port of the layer offset writer.
// master = the writer itself, slave = update source and mixer control slave.
interface mixer_layer_offset_writer_if;
   import mixer_ctrl_pkg::*;

   logic                upd_valid;
   logic                upd_ready;
   logic [COORD_W-1:0]  upd_x;
   logic [COORD_W-1:0]  upd_y;
   logic                layer_en;

   logic [ADDR_W-1:0]   avm_m0_address;
   logic                avm_m0_write;
   logic [DATA_W-1:0]   avm_m0_writedata;
   logic [BE_W-1:0]     avm_m0_byteenable;
   logic [BURST_W-1:0]  avm_m0_burstcount;
   logic                avm_m0_read;
   logic                avm_m0_waitrequest;

   modport master (
      input  upd_valid, upd_x, upd_y, layer_en, avm_m0_waitrequest,
      output upd_ready, avm_m0_address, avm_m0_write, avm_m0_writedata,
             avm_m0_byteenable, avm_m0_burstcount, avm_m0_read
   );

   modport slave (
      output upd_valid, upd_x, upd_y, layer_en, avm_m0_waitrequest,
      input  upd_ready, avm_m0_address, avm_m0_write, avm_m0_writedata,
             avm_m0_byteenable, avm_m0_burstcount, avm_m0_read
   );

endinterface

// File: rtl/mixer_layer_offset_writer.sv
// Holds the newest clamped layer offset and writes X, Y and CTRL to the mixer
// at the next frame_start as three back-to-back Avalon-MM single writes.
module mixer_layer_offset_writer
   import mixer_ctrl_pkg::*;
#(
   parameter int unsigned LAYER        = 1,
   parameter int unsigned LAYER_BASE   = 8,
   parameter int unsigned LAYER_STRIDE = 5,
   parameter int unsigned MAX_X        = 1279,
   parameter int unsigned MAX_Y        = 719
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 frame_start,
   output logic                 busy,
   output logic [DROP_W-1:0]    drop_count,
   mixer_layer_offset_writer_if.master bus
);

   localparam int unsigned X_ADDR = LAYER_BASE + LAYER * LAYER_STRIDE + REG_X;
   localparam int unsigned Y_ADDR = LAYER_BASE + LAYER * LAYER_STRIDE + REG_Y;
   localparam int unsigned C_ADDR = LAYER_BASE + LAYER * LAYER_STRIDE + REG_CTRL;

   state_t              state;
   logic                pending_valid;
   logic [COORD_W-1:0]  pend_x;
   logic [COORD_W-1:0]  pend_y;
   logic                pend_en;
   logic [COORD_W-1:0]  work_y;
   logic                work_en;
   logic                busy_q;
   logic [DROP_W-1:0]   drop_q;
   logic                write_q;
   logic [ADDR_W-1:0]   address_q;
   logic [DATA_W-1:0]   writedata_q;
   logic [BE_W-1:0]     byteenable_q;
   logic [BURST_W-1:0]  burstcount_q;
   logic                consume;

   assign consume = (state == ST_ARMED) && frame_start;

   // Pending capture, drop accounting and the write sequencer.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= ST_IDLE;
         pending_valid <= 1'b0;
         pend_x        <= '0;
         pend_y        <= '0;
         pend_en       <= 1'b0;
         work_y        <= '0;
         work_en       <= 1'b0;
         busy_q        <= 1'b0;
         drop_q        <= '0;
         write_q       <= 1'b0;
         address_q     <= '0;
         writedata_q   <= '0;
         byteenable_q  <= '0;
         burstcount_q  <= '0;
      end else begin
         if (bus.upd_valid) begin
            pend_x        <= clamp_coord(bus.upd_x, COORD_W'(MAX_X));
            pend_y        <= clamp_coord(bus.upd_y, COORD_W'(MAX_Y));
            pend_en       <= bus.layer_en;
            pending_valid <= 1'b1;
            if (pending_valid && !consume && (drop_q != '1))
               drop_q <= drop_q + DROP_W'(1);
         end else if (consume) begin
            pending_valid <= 1'b0;
         end

         case (state)
            ST_IDLE: begin
               if (pending_valid) state <= ST_ARMED;
            end
            ST_ARMED: begin
               if (frame_start) begin
                  state        <= ST_WR_X;
                  busy_q       <= 1'b1;
                  work_y       <= pend_y;
                  work_en      <= pend_en;
                  write_q      <= 1'b1;
                  address_q    <= ADDR_W'(X_ADDR);
                  writedata_q  <= {20'd0, pend_x};
                  byteenable_q <= BYTEEN_ALL;
                  burstcount_q <= BURST_W'(1);
               end
            end
            ST_WR_X: begin
               if (!bus.avm_m0_waitrequest) begin
                  state       <= ST_WR_Y;
                  address_q   <= ADDR_W'(Y_ADDR);
                  writedata_q <= {20'd0, work_y};
               end
            end
            ST_WR_Y: begin
               if (!bus.avm_m0_waitrequest) begin
                  state       <= ST_WR_CTRL;
                  address_q   <= ADDR_W'(C_ADDR);
                  writedata_q <= {31'd0, work_en};
               end
            end
            ST_WR_CTRL: begin
               if (!bus.avm_m0_waitrequest) begin
                  state        <= ST_IDLE;
                  busy_q       <= 1'b0;
                  write_q      <= 1'b0;
                  address_q    <= '0;
                  writedata_q  <= '0;
                  byteenable_q <= '0;
                  burstcount_q <= '0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.upd_ready         = 1'b1;
   assign bus.avm_m0_read       = 1'b0;
   assign bus.avm_m0_write      = write_q;
   assign bus.avm_m0_address    = address_q;
   assign bus.avm_m0_writedata  = writedata_q;
   assign bus.avm_m0_byteenable = byteenable_q;
   assign bus.avm_m0_burstcount = burstcount_q;
   assign busy                  = busy_q;
   assign drop_count            = drop_q;

endmodule

// File: tb/tb_mixer_layer_offset_writer.sv
// Scoreboard bench for mixer_layer_offset_writer: directed cases plus randomized updates.
module tb_mixer_layer_offset_writer;

   localparam int unsigned LAYER        = 1;
   localparam int unsigned LAYER_BASE   = 8;
   localparam int unsigned LAYER_STRIDE = 5;
   localparam int unsigned MAX_X        = 1279;
   localparam int unsigned MAX_Y        = 719;
   localparam int unsigned X_ADDR = LAYER_BASE + LAYER * LAYER_STRIDE;
   localparam int unsigned Y_ADDR = X_ADDR + 1;
   localparam int unsigned C_ADDR = X_ADDR + 2;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } beat_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        frame_start;
   logic        busy;
   logic [15:0] drop_count;

   mixer_layer_offset_writer_if vif ();

   mixer_layer_offset_writer #(
      .LAYER(LAYER), .LAYER_BASE(LAYER_BASE), .LAYER_STRIDE(LAYER_STRIDE),
      .MAX_X(MAX_X), .MAX_Y(MAX_Y)
   ) dut (
      .clk(clk), .reset(reset), .frame_start(frame_start),
      .busy(busy), .drop_count(drop_count), .bus(vif)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int wmode = 0;
   int stall_n = 0;
   int y_cycles = 0;

   beat_t sb[$];
   int    acc_q[$];

   // reference state of the offset holder
   bit          m_pend = 0;
   int unsigned m_x = 0, m_y = 0;
   bit          m_en = 0;
   int unsigned m_drop = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // waitrequest source: 0 none, 1 random, 2 always, 3 four-cycle stall on the Y beat
   always @(posedge clk) begin
      #1;
      case (wmode)
         1: vif.avm_m0_waitrequest = (($urandom % 3) == 0);
         2: vif.avm_m0_waitrequest = 1'b1;
         3: begin
            if (vif.avm_m0_write && vif.avm_m0_address == 32'(Y_ADDR) && stall_n < 4) begin
               vif.avm_m0_waitrequest = 1'b1;
               stall_n++;
            end else begin
               vif.avm_m0_waitrequest = 1'b0;
            end
         end
         default: vif.avm_m0_waitrequest = 1'b0;
      endcase
   end

   // monitor: every presented beat must match the scoreboard head; pop on accept
   always @(negedge clk) begin
      if (reset === 1'b0) begin
         if (vif.avm_m0_write) begin
            if (vif.avm_m0_address == 32'(Y_ADDR)) y_cycles++;
            n_vec++;
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                        vif.avm_m0_address, vif.avm_m0_writedata);
            end else begin
               if (vif.avm_m0_address !== sb[0].addr || vif.avm_m0_writedata !== sb[0].data ||
                   vif.avm_m0_byteenable !== 4'hF || vif.avm_m0_burstcount !== 11'd1) begin
                  n_err++;
                  $display("FAIL beat: got addr %0h data %0h be %0h bc %0d expected addr %0h data %0h be f bc 1",
                           vif.avm_m0_address, vif.avm_m0_writedata, vif.avm_m0_byteenable,
                           vif.avm_m0_burstcount, sb[0].addr, sb[0].data);
               end
               if (!vif.avm_m0_waitrequest) begin
                  void'(sb.pop_front());
                  acc_q.push_back(cyc);
               end
            end
         end else begin
            n_vec++;
            if (vif.avm_m0_byteenable !== 4'h0 || vif.avm_m0_burstcount !== 11'd0 ||
                vif.avm_m0_read !== 1'b0) begin
               n_err++;
               $display("FAIL idle_bus: got be %0h bc %0d rd %0b expected 0 0 0",
                        vif.avm_m0_byteenable, vif.avm_m0_burstcount, vif.avm_m0_read);
            end
         end
      end
   end

   function automatic int unsigned ref_min(input int unsigned v, input int unsigned m);
      return (v > m) ? m : v;
   endfunction

   // One cycle of stimulus with the reference model updated in the same step.
   task automatic drive_cycle(input bit v, input int unsigned x, input int unsigned y,
                              input bit en, input bit fs);
      beat_t b;
      if (fs && sb.size() == 0 && m_pend) begin
         b.addr = 32'(X_ADDR); b.data = 32'(m_x);       sb.push_back(b);
         b.addr = 32'(Y_ADDR); b.data = 32'(m_y);       sb.push_back(b);
         b.addr = 32'(C_ADDR); b.data = {31'd0, m_en};  sb.push_back(b);
         m_pend = 0;
      end
      if (v) begin
         if (m_pend && m_drop < 65535) m_drop++;
         m_pend = 1;
         m_x    = ref_min(x, MAX_X);
         m_y    = ref_min(y, MAX_Y);
         m_en   = en;
      end
      vif.upd_valid = v;
      vif.upd_x     = 12'(x);
      vif.upd_y     = 12'(y);
      vif.layer_en  = en;
      frame_start   = fs;
      @(posedge clk); #1;
      vif.upd_valid = 1'b0;
      frame_start   = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic upd(input int unsigned x, input int unsigned y, input bit en);
      drive_cycle(1'b1, x, y, en, 1'b0);
   endtask

   task automatic frame();
      drive_cycle(1'b0, 0, 0, 1'b0, 1'b1);
   endtask

   task automatic drain(input int budget);
      int k = 0;
      while (sb.size() != 0 && k < budget) begin @(posedge clk); #1; k++; end
      check("drain_outstanding", 32'(sb.size()), 32'd0);
      sb.delete();
   endtask

   initial begin
      int c0;
      reset         = 1'b1;
      frame_start   = 1'b0;
      vif.upd_valid = 1'b0;
      vif.upd_x     = '0;
      vif.upd_y     = '0;
      vif.layer_en  = 1'b0;
      idle(3);
      check("rst_write",     32'(vif.avm_m0_write), 32'd0);
      check("rst_address",   vif.avm_m0_address, 32'd0);
      check("rst_writedata", vif.avm_m0_writedata, 32'd0);
      check("rst_byteen",    32'(vif.avm_m0_byteenable), 32'd0);
      check("rst_burst",     32'(vif.avm_m0_burstcount), 32'd0);
      check("rst_busy",      32'(busy), 32'd0);
      check("rst_drop",      32'(drop_count), 32'd0);
      check("rst_ready",     32'(vif.upd_ready), 32'd1);
      reset = 1'b0;
      idle(2);

      // basic write with latency and back-to-back beats
      upd(100, 50, 1'b1);
      idle(3);
      acc_q.delete();
      c0 = cyc;
      frame();
      check("lat_write", 32'(vif.avm_m0_write), 32'd1);
      check("lat_busy",  32'(busy), 32'd1);
      drain(50);
      check("acc_count", 32'(acc_q.size()), 32'd3);
      if (acc_q.size() == 3) begin
         check("acc_x_cycle",    32'(acc_q[0]), 32'(c0 + 1));
         check("acc_y_cycle",    32'(acc_q[1]), 32'(c0 + 2));
         check("acc_ctrl_cycle", 32'(acc_q[2]), 32'(c0 + 3));
      end
      idle(1);
      check("done_busy", 32'(busy), 32'd0);

      // clamping
      upd(2000, 900, 1'b0);
      idle(3); frame(); drain(50); idle(3);

      // four-cycle stall on the Y beat
      wmode = 3; stall_n = 0; y_cycles = 0;
      upd(300, 200, 1'b1);
      idle(3); frame(); drain(50); idle(3);
      check("y_hold_cycles", 32'(y_cycles), 32'd5);
      wmode = 0;

      // only the newest of three updates survives
      upd(1, 2, 1'b1); upd(3, 4, 1'b0); upd(5, 6, 1'b1);
      check("drop_model", 32'(m_drop), 32'd2);
      idle(3); frame(); drain(50); idle(3);
      check("drop_count", 32'(drop_count), 32'(m_drop));

      // update while busy waits; frame_start while busy is ignored
      upd(10, 20, 1'b1);
      idle(3); frame();
      upd(30, 40, 1'b0);
      frame();
      drain(50); idle(3);
      frame(); drain(50); idle(3);
      check("busy_drop", 32'(drop_count), 32'(m_drop));

      // capture in the consume cycle is not a drop
      upd(111, 222, 1'b1);
      idle(3);
      drive_cycle(1'b1, 333, 444, 1'b0, 1'b1);
      drain(50); idle(3);
      frame(); drain(50); idle(3);
      check("consume_drop", 32'(drop_count), 32'(m_drop));

      // reset mid-sequence while stalled
      wmode = 2;
      idle(2);
      upd(77, 88, 1'b1); upd(99, 66, 1'b1);
      idle(3); frame();
      check("pre_rst_write", 32'(vif.avm_m0_write), 32'd1);
      reset = 1'b1;
      sb.delete(); m_pend = 0; m_drop = 0;
      idle(1);
      check("rst_abort_write", 32'(vif.avm_m0_write), 32'd0);
      check("rst_abort_busy",  32'(busy), 32'd0);
      check("rst_abort_drop",  32'(drop_count), 32'd0);
      reset = 1'b0;
      wmode = 0;
      idle(10);
      frame(); idle(5);
      upd(500, 600, 1'b1);
      idle(3); frame(); drain(50); idle(3);

      // randomized updates with random stalls
      wmode = 1;
      for (int it = 0; it < 30; it++) begin
         int k;
         k = $urandom_range(1, 3);
         for (int j = 0; j < k; j++) begin
            upd($urandom_range(0, 4095), $urandom_range(0, 4095), 1'($urandom % 2));
            idle($urandom_range(0, 2));
         end
         idle(3); frame(); drain(300); idle(3);
         check("rand_drop", 32'(drop_count), 32'(m_drop));
         check("rand_busy", 32'(busy), 32'd0);
      end
      wmode = 0;
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
